// File: rtl/decimal_entry_accumulator.sv
// decimal_entry_accumulator: debounced key entry of a decimal value, committed downstream via valid/ready
module decimal_entry_accumulator #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_DIGITS      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  digit_in,
    input  logic        key_enter_n,
    input  logic        key_delete_n,
    input  logic        key_commit_n,
    output logic [11:0] entry_value,
    output logic [2:0]  entry_digits,
    output logic [11:0] value_out,
    output logic        value_valid,
    input  logic        value_ready,
    output logic        reject
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    typedef enum logic {ENTRY, HOLD} state_t;
    state_t        state_q, state_d;
    logic [2:0]    key_n;
    logic [5:0]    sync_q, sync_d;
    logic [2:0]    deb_q, deb_d, arm_q, arm_d, press_q, press_d;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [11:0]   entry_q, entry_d, value_q, value_d;
    logic [2:0]    digits_q, digits_d;
    logic          valid_q, valid_d, reject_q, reject_d;
    logic [15:0]   cand;
    assign key_n = {key_commit_n, key_delete_n, key_enter_n};
    // Key path; a key only arms once seen released, so one held through reset never fires
    always_comb begin
        sync_d  = {sync_q[2:0], key_n};
        deb_d   = deb_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync_q[3+i] != deb_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES)) deb_d[i] = sync_q[3+i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        arm_d   = arm_q | sync_q[5:3];
        press_d = arm_q & deb_q & ~deb_d;
    end
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        digits_d = digits_q;
        value_d  = value_q;
        valid_d  = valid_q;
        reject_d = 1'b0;
        cand     = {4'd0, entry_q} * 16'd10 + {12'd0, digit_in};
        if (state_q == ENTRY) begin
            if (press_q[2]) begin
                if (digits_q == 3'd0) reject_d = 1'b1;
                else begin
                    value_d = entry_q;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end else if (press_q[1]) begin
                if (digits_q != 3'd0) begin
                    entry_d  = entry_q / 12'd10;
                    digits_d = digits_q - 3'd1;
                end
            end else if (press_q[0]) begin
                if (digit_in > 4'd9 || digits_q == 3'(MAX_DIGITS) || cand > 16'd4095) reject_d = 1'b1;
                else begin
                    entry_d  = cand[11:0];
                    digits_d = digits_q + 3'd1;
                end
            end
        end else begin
            reject_d = press_q[2] | press_q[0];
            if (valid_q && value_ready) begin
                valid_d  = 1'b0;
                entry_d  = '0;
                digits_d = '0;
                state_d  = ENTRY;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            deb_q    <= '1;
            arm_q    <= '0;
            press_q  <= '0;
            cnt_q    <= '{default: '0};
            state_q  <= ENTRY;
            entry_q  <= '0;
            digits_q <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            deb_q    <= deb_d;
            arm_q    <= arm_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            entry_q  <= entry_d;
            digits_q <= digits_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            reject_q <= reject_d;
        end
    end
    assign entry_value  = entry_q;
    assign entry_digits = digits_q;
    assign value_out    = value_q;
    assign value_valid  = valid_q;
    assign reject       = reject_q;
endmodule

// File: tb/tb_decimal_entry_accumulator.sv
// tb_decimal_entry_accumulator: table vectors, corner sequences and a random run against a digit-queue model
module tb_decimal_entry_accumulator;
    logic        clk = 1'b0, reset = 1'b1;
    logic [3:0]  digit_in = '0;
    logic        key_enter_n = 1'b1, key_delete_n = 1'b1, key_commit_n = 1'b1, value_ready = 1'b0;
    logic [11:0] entry_value, value_out;
    logic [2:0]  entry_digits;
    logic        value_valid, reject;
    int checks = 0, errors = 0, rej_total = 0;
    typedef struct {
        logic [2:0] keys;
        logic [3:0] digit;
        logic       ready;
        int ev; int ed; int vv; int vo; int rj;
    } vec_t;
    vec_t tab[$];
    int mq[$];
    int m_hold, m_out;
    decimal_entry_accumulator #(.DEBOUNCE_CYCLES(4), .MAX_DIGITS(4)) dut (
        .clk(clk), .reset(reset), .digit_in(digit_in),
        .key_enter_n(key_enter_n), .key_delete_n(key_delete_n), .key_commit_n(key_commit_n),
        .entry_value(entry_value), .entry_digits(entry_digits), .value_out(value_out),
        .value_valid(value_valid), .value_ready(value_ready), .reject(reject)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (reject) rej_total <= rej_total + 1;
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic add(input logic [2:0] k, input logic [3:0] d, input logic r,
                       input int ev, input int ed, input int vv, input int vo, input int rj);
        vec_t v;
        v.keys = k; v.digit = d; v.ready = r; v.ev = ev; v.ed = ed; v.vv = vv; v.vo = vo; v.rj = rj;
        tab.push_back(v);
    endtask
    task automatic op(input logic [2:0] k, input logic [3:0] d, input logic r, output int rj);
        int r0;
        @(negedge clk);
        r0 = rej_total;
        digit_in = d; value_ready = r;
        {key_commit_n, key_delete_n, key_enter_n} = ~k;
        repeat (10) @(negedge clk);
        {key_commit_n, key_delete_n, key_enter_n} = 3'b111;
        repeat (12) @(negedge clk);
        value_ready = 1'b0;
        rj = rej_total - r0;
    endtask
    task automatic check_all(input string tag, input int ev, input int ed, input int vv, input int vo, input int rj, input int arj);
        chk({tag, " entry_value"}, int'(entry_value), ev);
        chk({tag, " entry_digits"}, int'(entry_digits), ed);
        chk({tag, " value_valid"}, int'(value_valid), vv);
        chk({tag, " value_out"}, int'(value_out), vo);
        chk({tag, " reject_pulses"}, arj, rj);
    endtask
    function automatic int qval();
        int v = 0;
        foreach (mq[i]) v = v * 10 + mq[i];
        return v;
    endfunction
    function automatic int model_op(input logic [2:0] k, input int d, input logic r);
        int rj = 0;
        if (m_hold != 0 && r) begin m_hold = 0; mq.delete(); end
        if (m_hold == 0) begin
            if (k[2]) begin
                if (mq.size() == 0) rj = 1;
                else begin m_out = qval(); m_hold = 1; end
            end else if (k[1]) begin
                if (mq.size() > 0) void'(mq.pop_back());
            end else if (k[0]) begin
                if (d > 9 || mq.size() >= 4 || qval() * 10 + d > 4095) rj = 1;
                else mq.push_back(d);
            end
        end else if (k[2] || k[0]) rj = 1;
        if (m_hold != 0 && r) begin m_hold = 0; mq.delete(); end
        return rj;
    endfunction
    initial begin
        int rj;
        logic [2:0] k;
        int d, sel;
        logic r;
        add(3'b001, 4'd1, 0, 1, 1, 0, 0, 0);
        add(3'b001, 4'd2, 0, 12, 2, 0, 0, 0);
        add(3'b001, 4'd3, 0, 123, 3, 0, 0, 0);
        add(3'b010, 4'd0, 0, 12, 2, 0, 0, 0);
        add(3'b010, 4'd0, 0, 1, 1, 0, 0, 0);
        add(3'b010, 4'd0, 0, 0, 0, 0, 0, 0);
        add(3'b010, 4'd0, 0, 0, 0, 0, 0, 0);
        add(3'b001, 4'hA, 0, 0, 0, 0, 0, 1);
        add(3'b100, 4'd0, 0, 0, 0, 0, 0, 1);
        add(3'b001, 4'd4, 0, 4, 1, 0, 0, 0);
        add(3'b001, 4'd0, 0, 40, 2, 0, 0, 0);
        add(3'b001, 4'd9, 0, 409, 3, 0, 0, 0);
        add(3'b001, 4'd6, 0, 409, 3, 0, 0, 1);
        add(3'b001, 4'd5, 0, 4095, 4, 0, 0, 0);
        add(3'b001, 4'd1, 0, 4095, 4, 0, 0, 1);
        add(3'b010, 4'd0, 0, 409, 3, 0, 0, 0);
        add(3'b010, 4'd0, 0, 40, 2, 0, 0, 0);
        add(3'b010, 4'd0, 0, 4, 1, 0, 0, 0);
        add(3'b010, 4'd0, 0, 0, 0, 0, 0, 0);
        add(3'b001, 4'd1, 0, 1, 1, 0, 0, 0);
        add(3'b001, 4'd2, 0, 12, 2, 0, 0, 0);
        add(3'b001, 4'd3, 0, 123, 3, 0, 0, 0);
        add(3'b100, 4'd0, 0, 123, 3, 1, 123, 0);
        add(3'b001, 4'd7, 0, 123, 3, 1, 123, 1);
        add(3'b010, 4'd0, 0, 123, 3, 1, 123, 0);
        add(3'b100, 4'd0, 0, 123, 3, 1, 123, 1);
        add(3'b000, 4'd0, 1, 0, 0, 0, 123, 0);
        add(3'b001, 4'd0, 0, 0, 1, 0, 123, 0);
        add(3'b001, 4'd5, 0, 5, 2, 0, 123, 0);
        add(3'b111, 4'd1, 0, 5, 2, 1, 5, 0);
        add(3'b000, 4'd0, 1, 0, 0, 0, 5, 0);
        add(3'b001, 4'hF, 0, 0, 0, 0, 5, 1);
        add(3'b011, 4'd2, 0, 0, 0, 0, 5, 0);
        add(3'b001, 4'd9, 0, 9, 1, 0, 5, 0);
        add(3'b011, 4'd2, 0, 0, 0, 0, 5, 0);
        repeat (3) @(negedge clk);
        check_all("reset", 0, 0, 0, 0, 0, int'(reject));
        reset = 1'b0;
        repeat (5) @(negedge clk);
        digit_in = 4'd1; key_enter_n = 1'b0;
        repeat (7) @(negedge clk);
        chk("latency before edge 7", int'(entry_value), 0);
        @(negedge clk);
        chk("latency at edge 7", int'(entry_value), 1);
        repeat (3) @(negedge clk);
        key_enter_n = 1'b1;
        repeat (12) @(negedge clk);
        op(3'b010, 4'd0, 0, rj);
        check_all("latency cleanup", 0, 0, 0, 0, 0, rj);
        rj = rej_total;
        digit_in = 4'd7;
        for (int i = 0; i < 11; i++) begin
            key_enter_n = i[0];
            repeat (2) @(negedge clk);
        end
        key_enter_n = 1'b1;
        repeat (12) @(negedge clk);
        check_all("glitch", 0, 0, 0, 0, 0, rej_total - rj);
        foreach (tab[i]) begin
            op(tab[i].keys, tab[i].digit, tab[i].ready, rj);
            check_all($sformatf("vec%0d", i), tab[i].ev, tab[i].ed, tab[i].vv, tab[i].vo, tab[i].rj, rj);
        end
        op(3'b001, 4'd4, 0, rj);
        op(3'b100, 4'd0, 0, rj);
        chk("hold before reset valid", int'(value_valid), 1);
        reset = 1'b1;
        @(negedge clk);
        check_all("reset in hold", 0, 0, 0, 0, 0, int'(reject));
        reset = 1'b0;
        repeat (5) @(negedge clk);
        digit_in = 4'd3; key_enter_n = 1'b0;
        repeat (15) @(negedge clk);
        chk("held key pre-reset", int'(entry_value), 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rj = rej_total;
        repeat (20) @(negedge clk);
        key_enter_n = 1'b1;
        repeat (12) @(negedge clk);
        check_all("held through reset", 0, 0, 0, 0, 0, rej_total - rj);
        op(3'b001, 4'd3, 0, rj);
        check_all("repress after reset", 3, 1, 0, 0, 0, rj);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        mq.delete(); m_hold = 0; m_out = 0;
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            k = sel < 5 ? 3'b001 : sel < 7 ? 3'b010 : sel < 8 ? 3'b100 : sel == 8 ? 3'($urandom_range(0, 7)) : 3'b000;
            d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            r = ($urandom_range(0, 2) == 0);
            op(k, 4'(d), r, rj);
            sel = model_op(k, d, r);
            check_all($sformatf("rand%0d", n), qval(), mq.size(), m_hold, m_out, sel, rj);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
